// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store initiator: turns EX/MEM load/store requests into a
// handshaked word-addressed memory access and stalls the pipeline until it completes.
module lsu_mem_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       result_EX_MEM,
    input  logic [31:0]       Write_Data_EX_MEM,
    input  logic              Mem_Write_EX_MEM,
    input  logic              Mem_Read_EX_MEM,
    input  logic [2:0]        funct3_EX_MEM,
    output logic [31:0]       Read_Data,
    output logic              lsu_stall,
    output logic              access_err,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [7:0]        cnt_q;
    logic [1:0]        addr_lo_q;
    logic [2:0]        funct3_q;
    logic              rd_q;
    logic              we_q;
    logic [ADDR_W-3:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic              acc_err_q;
    logic              bus_err_q;
    logic [31:0]       rdata_q;

    logic              op_valid;
    logic              op_illegal;
    logic              capture;
    logic              timeout_hit;
    logic [31:0]       lane_wdata;
    logic [3:0]        lane_wstrb;

    function automatic logic access_illegal(input logic rd, input logic wr,
                                            input logic [2:0] f3, input logic [1:0] a);
        logic bad;
        case (f3)
            3'b000:  bad = 1'b0;
            3'b001:  bad = a[0];
            3'b010:  bad = (a != 2'b00);
            3'b100:  bad = wr;
            3'b101:  bad = wr | a[0];
            default: bad = 1'b1;
        endcase
        return bad | (rd & wr);
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [2:0] f3,
                                                input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    assign op_valid   = Mem_Read_EX_MEM | Mem_Write_EX_MEM;
    assign op_illegal = access_illegal(Mem_Read_EX_MEM, Mem_Write_EX_MEM,
                                       funct3_EX_MEM, result_EX_MEM[1:0]);

    // Store data is replicated across lanes; the strobe selects the live bytes.
    always_comb begin
        lane_wdata = '0;
        lane_wstrb = '0;
        if (Mem_Write_EX_MEM) begin
            case (funct3_EX_MEM[1:0])
                2'b00: begin
                    lane_wdata = {4{Write_Data_EX_MEM[7:0]}};
                    lane_wstrb = 4'b0001 << result_EX_MEM[1:0];
                end
                2'b01: begin
                    lane_wdata = {2{Write_Data_EX_MEM[15:0]}};
                    lane_wstrb = 4'b0011 << {result_EX_MEM[1], 1'b0};
                end
                default: begin
                    lane_wdata = Write_Data_EX_MEM;
                    lane_wstrb = 4'b1111;
                end
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        lsu_stall   = 1'b0;
        mem_req     = 1'b0;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (op_valid) begin
                    lsu_stall = 1'b1;
                    state_d   = op_illegal ? DONE : REQ;
                end
            end
            REQ: begin
                lsu_stall = 1'b1;
                mem_req   = 1'b1;
                if (mem_gnt) begin
                    if (we_q) begin
                        state_d = DONE;
                    end else if (mem_rvalid) begin
                        capture = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = RSP;
                    end
                end else if (cnt_q == TO_LAST) begin
                    timeout_hit = 1'b1;
                    state_d     = DONE;
                end
            end
            RSP: begin
                lsu_stall = 1'b1;
                if (mem_rvalid) begin
                    capture = 1'b1;
                    state_d = DONE;
                end else if (cnt_q == TO_LAST) begin
                    timeout_hit = 1'b1;
                    state_d     = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (state_q == REQ || state_q == RSP) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    // Access attributes are frozen when the op is accepted so the bus sees stable values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_lo_q <= '0;
            funct3_q  <= '0;
            rd_q      <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            acc_err_q <= 1'b0;
            bus_err_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            acc_err_q <= (state_q == IDLE) && op_valid && op_illegal;
            bus_err_q <= timeout_hit;
            if (state_q == IDLE && op_valid) begin
                addr_lo_q <= result_EX_MEM[1:0];
                funct3_q  <= funct3_EX_MEM;
                rd_q      <= Mem_Read_EX_MEM;
                we_q      <= Mem_Write_EX_MEM;
                addr_q    <= result_EX_MEM[ADDR_W-1:2];
                wdata_q   <= lane_wdata;
                wstrb_q   <= lane_wstrb;
            end
            if (capture) begin
                rdata_q <= load_extend(mem_rdata, funct3_q, addr_lo_q);
            end else if (timeout_hit && rd_q) begin
                rdata_q <= '0;
            end else if (state_q == IDLE && op_valid && op_illegal && Mem_Read_EX_MEM) begin
                rdata_q <= '0;
            end
        end
    end

    assign Read_Data  = rdata_q;
    assign access_err = acc_err_q;
    assign bus_err    = bus_err_q;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_wstrb  = wstrb_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed scenarios plus random loads/stores checked
// against a transaction-level model of latency, lanes, extension and errors.
module tb_lsu_mem_ctrl;

    localparam int TIMEOUT = 4;
    localparam int ADDR_W  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       result_EX_MEM;
    logic [31:0]       Write_Data_EX_MEM;
    logic              Mem_Write_EX_MEM;
    logic              Mem_Read_EX_MEM;
    logic [2:0]        funct3_EX_MEM;
    logic [31:0]       Read_Data;
    logic              lsu_stall;
    logic              access_err;
    logic              bus_err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_rd;

    lsu_mem_ctrl #(.TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .result_EX_MEM     (result_EX_MEM),
        .Write_Data_EX_MEM (Write_Data_EX_MEM),
        .Mem_Write_EX_MEM  (Mem_Write_EX_MEM),
        .Mem_Read_EX_MEM   (Mem_Read_EX_MEM),
        .funct3_EX_MEM     (funct3_EX_MEM),
        .Read_Data         (Read_Data),
        .lsu_stall         (lsu_stall),
        .access_err        (access_err),
        .bus_err           (bus_err),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_wstrb         (mem_wstrb),
        .mem_gnt           (mem_gnt),
        .mem_rvalid        (mem_rvalid),
        .mem_rdata         (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference rules for one access, computed from the architectural definitions.
    function automatic bit ref_illegal(bit rd, bit wr, int f3, int a);
        bit bad;
        case (f3)
            0:       bad = 0;
            1:       bad = (a % 2) != 0;
            2:       bad = (a % 4) != 0;
            4:       bad = wr;
            5:       bad = wr || ((a % 2) != 0);
            default: bad = 1;
        endcase
        return bad || (rd && wr);
    endfunction

    function automatic logic [31:0] ref_load(logic [31:0] w, int f3, int a);
        logic [31:0] byt, half;
        byt  = (w >> (8 * (a % 4))) & 32'hFF;
        half = (w >> (8 * (a % 4))) & 32'hFFFF;
        case (f3)
            0:       return (byt >= 128) ? byt + 32'hFFFF_FF00 : byt;
            1:       return (half >= 32768) ? half + 32'hFFFF_0000 : half;
            4:       return byt;
            5:       return half;
            default: return w;
        endcase
    endfunction

    // Called at a falling edge with the DUT idle; returns one cycle after DONE.
    task automatic run_op(input bit rd, input bit wr, input int f3, input logic [31:0] addr,
                          input logic [31:0] wd, input int gd, input int rvd,
                          input logic [31:0] rdata);
        bit          illegal, tmo, done;
        int          exp_stall, exp_req, c, stall_cnt, req_cnt, gnt_cyc, acc_cnt, bus_cnt;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
        int          a;
        a = int'(addr[1:0]);
        illegal = ref_illegal(rd, wr, f3, a);
        tmo = 0;
        if (illegal) begin
            exp_stall = 1; exp_req = 0;
        end else if (gd >= TIMEOUT) begin
            tmo = 1; exp_req = TIMEOUT; exp_stall = 1 + TIMEOUT;
        end else if (wr) begin
            exp_req = gd + 1; exp_stall = gd + 2;
        end else if (rvd > TIMEOUT) begin
            tmo = 1; exp_req = gd + 1; exp_stall = gd + 2 + TIMEOUT;
        end else begin
            exp_req = gd + 1; exp_stall = gd + 2 + rvd;
        end
        exp_wdata = 32'h0;
        exp_wstrb = 4'h0;
        if (wr && f3 == 0) begin
            exp_wdata = (wd & 32'hFF) * 32'h0101_0101; exp_wstrb = 4'(1 << a);
        end else if (wr && f3 == 1) begin
            exp_wdata = (wd & 32'hFFFF) * 32'h0001_0001; exp_wstrb = 4'(3 << a);
        end else if (wr) begin
            exp_wdata = wd; exp_wstrb = 4'hF;
        end
        if (rd) last_rd = (illegal || tmo) ? 32'h0 : ref_load(rdata, f3, a);

        Mem_Read_EX_MEM   = rd;
        Mem_Write_EX_MEM  = wr;
        funct3_EX_MEM     = 3'(f3);
        result_EX_MEM     = addr;
        Write_Data_EX_MEM = wd;
        mem_rdata         = rdata;
        c = 0; stall_cnt = 0; req_cnt = 0; gnt_cyc = -1; acc_cnt = 0; bus_cnt = 0; done = 0;
        while (!done && c < 64) begin
            #1;
            mem_gnt = mem_req && (req_cnt == gd);
            if (mem_gnt && gnt_cyc < 0) gnt_cyc = c;
            mem_rvalid = rd && (gnt_cyc >= 0) && (c == gnt_cyc + rvd);
            if (mem_req) begin
                if (req_cnt == 0) begin
                    chk("mem_addr", 32'(mem_addr), addr >> 2);
                    chk("mem_we", 32'(mem_we), 32'(wr));
                    chk("mem_wstrb", 32'(mem_wstrb), 32'(exp_wstrb));
                    if (wr) chk("mem_wdata", mem_wdata, exp_wdata);
                end
                req_cnt++;
            end
            acc_cnt += int'(access_err);
            bus_cnt += int'(bus_err);
            if (lsu_stall) begin
                stall_cnt++;
            end else if (c > 0) begin
                done = 1;
                chk("done_access_err", 32'(access_err), 32'(illegal));
                chk("done_bus_err", 32'(bus_err), 32'(tmo));
                chk("read_data", Read_Data, last_rd);
            end
            if (!done) begin
                @(negedge clk);
                c++;
            end
        end
        if (!done) chk("done_reached", 32'd0, 32'd1);
        chk("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
        chk("req_cycles", 32'(req_cnt), 32'(exp_req));
        chk("access_err_pulses", 32'(acc_cnt), 32'(illegal));
        chk("bus_err_pulses", 32'(bus_cnt), 32'(tmo));
        Mem_Read_EX_MEM  = 1'b0;
        Mem_Write_EX_MEM = 1'b0;
        mem_gnt          = 1'b0;
        mem_rvalid       = 1'b0;
        @(negedge clk);
        #1;
        chk("idle_stall", 32'(lsu_stall), 32'd0);
    endtask

    // Reset lands during REQ or RSP of a word load with the EX/MEM op flushed.
    task automatic reset_mid(input bit in_rsp);
        Mem_Read_EX_MEM = 1'b1;
        funct3_EX_MEM   = 3'b010;
        result_EX_MEM   = 32'h40;
        @(negedge clk);
        #1;
        chk("rst_pre_req", 32'(mem_req), 32'd1);
        if (in_rsp) begin
            mem_gnt = 1'b1;
            @(negedge clk);
            #1;
            mem_gnt = 1'b0;
            chk("rst_pre_rsp_stall", 32'(lsu_stall), 32'd1);
        end
        Mem_Read_EX_MEM = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_stall", 32'(lsu_stall), 32'd0);
        chk("rst_read_data", Read_Data, 32'd0);
        last_rd = 32'h0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        result_EX_MEM = '0; Write_Data_EX_MEM = '0; Mem_Write_EX_MEM = 1'b0;
        Mem_Read_EX_MEM = 1'b0; funct3_EX_MEM = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        last_rd = 32'h0;
        repeat (2) @(negedge clk);
        chk("reset_read_data", Read_Data, 32'd0);
        chk("reset_stall", 32'(lsu_stall), 32'd0);
        chk("reset_req", 32'(mem_req), 32'd0);
        chk("reset_errs", {30'd0, access_err, bus_err}, 32'd0);
        chk("reset_bus", {mem_we, mem_wstrb, mem_wdata[26:0]}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(1, 0, 2, 32'h10, 32'h0, 0, 1, 32'hDEAD_BEEF);
        run_op(0, 1, 0, 32'h13, 32'h0000_00A5, 0, 0, 32'h0);
        run_op(1, 0, 0, 32'h21, 32'h0, 0, 1, 32'h0000_8000);
        run_op(1, 0, 4, 32'h21, 32'h0, 0, 1, 32'h0000_8000);
        reset_mid(1);
        run_op(1, 0, 2, 32'h10, 32'h0, 0, 1, 32'h1234_5678);
        run_op(0, 1, 1, 32'h7, 32'h0000_BEEF, 0, 0, 32'h0);
        run_op(1, 0, 2, 32'h2, 32'h0, 0, 1, 32'hFFFF_FFFF);
        run_op(0, 1, 1, 32'h6, 32'h0000_BEEF, 1, 0, 32'h0);
        run_op(1, 0, 1, 32'h6, 32'h0, 0, 0, 32'h8001_0000);
        run_op(1, 0, 2, 32'h20, 32'h0, 10, 1, 32'hCAFE_F00D);
        run_op(1, 0, 2, 32'h24, 32'h0, 1, 7, 32'hCAFE_F00D);
        reset_mid(0);

        for (int i = 0; i < 200; i++) begin
            int  r, f3;
            bit  rd, wr;
            r = int'($urandom_range(0, 9));
            rd = (r == 0) || (r < 5);
            wr = (r == 0) || (r >= 5);
            f3 = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7))
                                              : int'($urandom_range(0, 5));
            if (f3 == 3) f3 = 2;
            run_op(rd, wr, f3, $urandom, $urandom,
                   int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
